// File: rtl/dmem_sync_be.sv
// -----------------------------------------------------------------------------
// dmem_sync_be
// Synchronous byte-enabled data memory for the MIPS32 datapath.
//
// Serves LB/LBU/LH/LHU/LW/SB/SH/SW accesses over a valid/ready handshake.
// Byte lanes are little-endian. One access is in flight at a time, and
// WAIT_STATES extra cycles can be inserted to model slow memory.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_W       width of the byte address
//   WAIT_STATES  extra cycles between accept and response (0..15)
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   req_valid     request present
//   req_ready     block can accept a request (IDLE only)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10/11 word
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   addr          byte address; bits above the array size are ignored
//   wdata         store data (low byte/half used for SB/SH)
//   rsp_valid     one-cycle response strobe
//   rdata         extended load result; 0 for stores
//   misalign      misaligned-access flag, qualified by rsp_valid
//                 (only when DMEM_MISALIGN_TRAP_EN is defined)
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  defined: misaligned accesses are suppressed and
//                          flagged. Undefined: misaligned addresses are
//                          force-aligned and the access completes normally.
// -----------------------------------------------------------------------------
module dmem_sync_be #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          lat_we;
    logic [1:0]    lat_size;
    logic          lat_unsigned;
    logic [AW-1:0] lat_idx;
    logic [1:0]    lat_lane;

    logic          accept;
    logic          enter_resp;
    logic          cur_we;
    logic [1:0]    cur_size;
    logic          cur_unsigned;
    logic [AW-1:0] cur_idx;
    logic [1:0]    cur_lane_raw;
    logic [1:0]    cur_lane;
    logic          do_access;
    logic [3:0]    be;
    logic [31:0]   wr_word;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;

    // Address bits above the array size wrap away by design.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[ADDR_W-1:AW+2];

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && (state == S_IDLE);

    // In IDLE the access is decoded straight from the request so that stores
    // commit, and zero-wait loads read, on the accept edge. Afterwards the
    // latched copy is used and the inputs are don't-care.
    assign cur_we       = (state == S_IDLE) ? req_we          : lat_we;
    assign cur_size     = (state == S_IDLE) ? req_size        : lat_size;
    assign cur_unsigned = (state == S_IDLE) ? req_unsigned    : lat_unsigned;
    assign cur_idx      = (state == S_IDLE) ? addr[AW+1:2]    : lat_idx;
    assign cur_lane_raw = (state == S_IDLE) ? addr[1:0]       : lat_lane;

    assign enter_resp = ((state == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && (cnt == 4'd0));

`ifdef DMEM_MISALIGN_TRAP_EN
    logic cur_mis;
    logic mis_q;

    always_comb begin
        cur_mis = 1'b0;
        case (cur_size)
            2'b00:   cur_mis = 1'b0;
            2'b01:   cur_mis = cur_lane_raw[0];
            default: cur_mis = (cur_lane_raw != 2'b00);
        endcase
    end

    assign do_access = !cur_mis;
    assign misalign  = mis_q && (state == S_RESP);
`else
    assign do_access = 1'b1;
`endif

    // Force-align the lane: halves to an even lane, words to lane 0. With the
    // trap enabled misaligned accesses are suppressed, so this is harmless.
    always_comb begin
        cur_lane = 2'b00;
        be       = 4'b0000;
        wr_word  = wdata;
        case (cur_size)
            2'b00: begin
                cur_lane = cur_lane_raw;
                be       = 4'b0001 << cur_lane_raw;
                wr_word  = {4{wdata[7:0]}};
            end
            2'b01: begin
                cur_lane = {cur_lane_raw[1], 1'b0};
                be       = cur_lane_raw[1] ? 4'b1100 : 4'b0011;
                wr_word  = {2{wdata[15:0]}};
            end
            default: begin
                cur_lane = 2'b00;
                be       = 4'b1111;
                wr_word  = wdata;
            end
        endcase
    end

    // Load path: pick the lane, shift it to bit 0, then extend.
    always_comb begin
        rd_word  = mem[cur_idx];
        rd_byte  = rd_word[8*cur_lane +: 8];
        rd_half  = cur_lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (cur_size)
            2'b00:   load_val = cur_unsigned ? {24'd0, rd_byte}
                                             : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = cur_unsigned ? {16'd0, rd_half}
                                             : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // NOTE: the array has no reset branch; clearing it would force it out of
    // RAM macros into flops, and its contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (accept && cur_we && do_access) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[cur_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            rdata <= 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_idx      <= addr[AW+1:2];
                        lat_lane     <= addr[1:0];
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // rdata is captured once per transaction and then held.
            if (enter_resp) begin
                rdata <= (cur_we || !do_access) ? 32'd0 : load_val;
`ifdef DMEM_MISALIGN_TRAP_EN
                mis_q <= cur_mis;
`endif
            end
        end
    end

endmodule
